// File: rtl/tag_streamer.sv
// tag_streamer: buffers 32-bit tag records in a FIFO and streams them LSB-first to the omux.
// Optional per-record XOR checksum byte is compiled in with TAG_STREAMER_CKSUM_EN.
module tag_streamer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [31:0]           rec_data_i,
    input  logic                  rec_valid_i,
    output logic [7:0]            omux_data_o,
    output logic                  omux_req_o,
    input  logic                  omux_sel_i,
    output logic [DEPTH_LOG2:0]   fill_o,
    output logic [15:0]           lost_o,
    input  logic                  lost_clr_i
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FILL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   FILL_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam int                    BURST_W    = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0]    BURST_LAST = BURST_W'(MAX_BURST - 1);
`ifdef TAG_STREAMER_CKSUM_EN
    localparam logic [2:0]            LAST_BYTE  = 3'd4;
`else
    localparam logic [2:0]            LAST_BYTE  = 3'd3;
`endif

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   fill_q;
    logic [DEPTH_LOG2:0]   fill_d;
    logic [15:0]           lost_q;
    logic [15:0]           lost_d;
    state_e                state_q;
    logic                  req_q;
    logic [2:0]            byte_idx_q;
    logic [BURST_W-1:0]    burst_q;

    logic [31:0]           head;
    logic [7:0]            head_byte;
    logic                  last_byte;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign head      = mem_q[rd_ptr_q];
    assign last_byte = (byte_idx_q == LAST_BYTE);
    assign pop       = (state_q == SEND) && omux_sel_i && last_byte;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the record.
    assign push      = rec_valid_i && ((fill_q != FILL_FULL) || pop);
    assign drop      = rec_valid_i && !push;

    always_comb begin
        head_byte = 8'h00;
        case (byte_idx_q)
            3'd0:    head_byte = head[7:0];
            3'd1:    head_byte = head[15:8];
            3'd2:    head_byte = head[23:16];
            3'd3:    head_byte = head[31:24];
`ifdef TAG_STREAMER_CKSUM_EN
            3'd4:    head_byte = head[7:0] ^ head[15:8] ^ head[23:16] ^ head[31:24];
`endif
            default: head_byte = 8'h00;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_comb begin
        lost_d = lost_q;
        if (drop) begin
            if (lost_clr_i) begin
                lost_d = 16'd1;
            end else if (lost_q != 16'hFFFF) begin
                lost_d = lost_q + 16'd1;
            end
        end else if (lost_clr_i) begin
            lost_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            lost_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fill_q <= fill_d;
            lost_q <= lost_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            byte_idx_q <= '0;
            burst_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_q <= 1'b0;
                    if (fill_q != '0) begin
                        req_q      <= 1'b1;
                        byte_idx_q <= '0;
                        burst_q    <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (omux_sel_i) begin
                        if (!last_byte) begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                        end else begin
                            byte_idx_q <= '0;
                            burst_q    <= burst_q + 1'b1;
                            // A push landing on the final pop of an emptying FIFO waits for a new request.
                            if ((burst_q == BURST_LAST) || (fill_q == FILL_ONE)) begin
                                req_q   <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign omux_data_o = (state_q == SEND) ? head_byte : 8'h00;
    assign omux_req_o  = req_q;
    assign fill_o      = fill_q;
    assign lost_o      = lost_q;

endmodule

// File: doc/tag_streamer.md
# tag_streamer

Buffered writer-side client of the host output multiplexer. It accepts 32-bit tag records from the tagger core without back-pressure and stores them in an internal FIFO. It serializes the records LSB-first into bytes and emits them through the omux request/select handshake. Records that arrive while the FIFO is full are dropped and counted. The transmit request is released at record boundaries so that other omux sources, e.g. register replies, get bus time.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 records.
- `MAX_BURST`, 16: maximum number of records sent per request grant; must be ≥1.

- `clk_i` input 1: system clock.
- `reset_ni` input 1: reset, asynchronous, active-low.
- `rec_data_i` input 32: tag record.
- `rec_valid_i` input 1: record strobe, one record per cycle high.
- `omux_data_o` output 8: current byte to the mux.
- `omux_req_o` output 1: request to the out mux.
- `omux_sel_i` input 1: one-cycle pulse; the mux takes `omux_data_o` this cycle.
- `fill_o` output DEPTH_LOG2+1: FIFO occupancy in records.
- `lost_o` output 16: count of dropped records, saturating.
- `lost_clr_i` input 1: synchronous clear of `lost_o`.

## Operation
- **Reset values:** `omux_req_o`=0, `omux_data_o`=0x00, `fill_o`=0, `lost_o`=0. The FIFO is flushed and the FSM is in IDLE. Reset takes effect immediately, including mid-record; a partial record is discarded.
- **FIFO write:**
  - A record is accepted when `rec_valid_i` is high and either fill < 2^DEPTH_LOG2 or a pop occurs in the same cycle.
  - Otherwise the record is dropped and `lost_o` increments, saturating at 0xFFFF.
  - `lost_clr_i` together with a drop loads `lost_o`=1. `lost_clr_i` alone loads 0.
- **Head record** is the oldest FIFO entry. Its bytes go out in order [7:0], [15:8], [23:16], [31:24], followed by the checksum byte when that feature is compiled in (see Configuration). `byte_idx` selects the byte.
- **FSM states:**
  - IDLE:
    - `omux_req_o` is 0.
    - If fill ≠ 0: set `omux_req_o`←1, `byte_idx`←0, `burst`←0, and go to SEND.
  - SEND:
    - `omux_data_o` shows the head byte selected by `byte_idx`.
    - On `omux_sel_i` when the byte is not the last of its record: `byte_idx`++.
    - On `omux_sel_i` when the byte is the last of its record: pop the record, `burst`++, `byte_idx`←0.
    - If `burst`+1 = MAX_BURST, or the FIFO becomes empty after the pop, set `omux_req_o`←0 and go to IDLE.
    - Otherwise stay in SEND with the next record.
- **Request release:** `omux_req_o` never drops mid-record.
- **`omux_sel_i` outside SEND** is ignored.

## Timing
- `omux_req_o` and `byte_idx` are registered. `omux_data_o` is a mux of the registered head and `byte_idx`. It is stable from request assertion until the cycle after each `omux_sel_i`.
- **Latency:**
  - Record strobed in cycle N into an empty FIFO gives fill=1 in N+1.
  - `omux_req_o` goes high in N+2.
  - The first byte is valid in N+2.
- **Gap after release:** `omux_req_o` falls in the cycle after the final `omux_sel_i` of a burst. It stays low for at least 1 cycle before it can be reasserted, so the mux returns to idle.
- **Back-to-back transfer:** `omux_sel_i` may pulse on consecutive cycles, and one byte is consumed per pulse.
- **Simultaneous push and pop:**
  - fill is unchanged.
  - When the FIFO is full, the push is accepted.
  - A push into an empty FIFO during the final pop does not extend the burst; the FSM goes to IDLE and re-requests.

## Configuration
- `TAG_STREAMER_CKSUM_EN`
  - Defined: each record is 5 bytes. Byte 4 is the XOR of bytes 0–3.
  - Undefined: each record is 4 bytes, and the checksum logic is absent.

## Test plan
- **Single record:** push 0x11223344 into an idle block; pulse `omux_sel_i` every 3 cycles → bytes 0x44, 0x33, 0x22, 0x11. `omux_req_o` is 0 the cycle after the 4th select, and fill=0.
- **Checksum (`TAG_STREAMER_CKSUM_EN` defined):** same stimulus → 5th byte 0x44. Request drops after the 5th select.
- **Burst limit:** MAX_BURST=16; push 20 records, then hold `omux_sel_i` high → request drops after 64 selects and is low for ≥1 cycle. It then reasserts, and the remaining 16 bytes arrive in order.
- **Overflow:**
  - DEPTH_LOG2=2, no selects; push 7 records → fill=4, `lost_o`=3.
  - `lost_clr_i` → 0.
  - `lost_clr_i` together with a dropped push → 1.
  - 0xFFFF drops → `lost_o` holds 0xFFFF.
- **Full push+pop:** with fill=4, push in the cycle of the final select → record accepted, fill stays 4, `lost_o` unchanged.
- **Reset mid-record:** assert `reset_ni` low after 2 selects → `omux_req_o`=0 with no clock edge, fill=0. After release, push 0xAABBCCDD → first byte 0xDD.
